// File: rtl/rand_range.sv
// Maps raw LFSR words to an unbiased integer in [0, bound) by masked rejection,
// with a bounded retry count and a subtract-the-bound fallback for fixed worst-case latency.
module rand_range #(
  parameter int LfsrWidth  = 31,
  parameter int OutWidth   = 8,
  parameter int MaxRetries = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LfsrWidth-1:0] lfsr_data,
  output logic                 lfsr_enable,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OutWidth-1:0]  req_bound,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [OutWidth-1:0]  rsp_value,
  output logic                 rsp_error
);

  localparam int TriesW = $clog2(MaxRetries + 1);
  localparam logic [TriesW-1:0] TriesMax = TriesW'(MaxRetries);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]          r_state;
  logic [TriesW-1:0]   r_tries;
  logic [OutWidth-1:0] r_bound;
  logic [OutWidth-1:0] r_mask;
  logic [OutWidth-1:0] r_value;
  logic                r_error;

  logic [OutWidth-1:0] w_mask;
  logic [OutWidth-1:0] w_cand;
  logic                w_accept;
  logic                w_last_try;

  // Only the low OutWidth bits of the LFSR word are consumed.
  generate
    if (LfsrWidth > OutWidth) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^lfsr_data[LfsrWidth-1:OutWidth];
    end
  endgenerate

  // Smear the MSB of (N-1) downward: smallest all-ones mask covering N-1.
  always_comb begin
    w_mask = req_bound - OutWidth'(1);
    for (int i = 1; i < OutWidth; i = i * 2) begin
      w_mask = w_mask | (w_mask >> i);
    end
  end

  assign w_cand     = lfsr_data[OutWidth-1:0] & r_mask;
  assign w_accept   = (w_cand < r_bound);
  assign w_last_try = (r_tries == TriesMax);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_tries <= '0;
      r_bound <= '0;
      r_mask  <= '0;
      r_value <= '0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_bound <= req_bound;
            r_tries <= '0;
            r_mask  <= w_mask;
            if (req_bound == '0) begin
              r_error <= 1'b1;
              r_value <= '0;
              r_state <= S_RESP;
            end else begin
              r_state <= S_SAMPLE;
            end
          end
        end
        S_SAMPLE: begin
          if (w_accept) begin
            r_value <= w_cand;
            r_state <= S_RESP;
          end else if (w_last_try) begin
            // Candidate is below 2*N, so one subtraction lands in range.
            r_value <= w_cand - r_bound;
            r_state <= S_RESP;
          end else begin
            r_tries <= r_tries + TriesW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_error <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode from state only; no path from req_valid/rsp_ready.
  assign req_ready   = (r_state == S_IDLE);
  assign lfsr_enable = (r_state == S_SAMPLE);
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_value   = r_value;
  assign rsp_error   = r_error;

endmodule

// File: tb/tb_rand_range.sv
// Directed bench for rand_range: a table-driven LFSR stand-in advances one word per
// lfsr_enable cycle; each scenario task checks its own expected values inline.
module tb_rand_range;

  logic        clk;
  logic        rst;
  logic [30:0] lfsr_data;
  logic        lfsr_enable;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_bound;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_value;
  logic        rsp_error;

  int checks = 0;
  int errors = 0;

  logic [30:0] tab [0:15];
  int          en_count = 0;
  int          start = 0;
  logic [3:0]  idx;

  rand_range #(.LfsrWidth(31), .OutWidth(8), .MaxRetries(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .lfsr_data   (lfsr_data),
    .lfsr_enable (lfsr_enable),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_bound   (req_bound),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_value   (rsp_value),
    .rsp_error   (rsp_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (lfsr_enable) en_count <= en_count + 1;
  end

  assign idx       = 4'(en_count - start);
  assign lfsr_data = tab[idx];

  task automatic load(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    start  = en_count;
    tab[0] = {23'h2D2D2D, b0};
    tab[1] = {23'h1A2B3C, b1};
    tab[2] = {23'h7F00F7, b2};
    for (int i = 3; i < 16; i++) tab[i] = {23'h555555, b3};
  endtask

  // Issue one request and wait for the response; lat counts SAMPLE cycles.
  task automatic do_req(input logic [7:0] n, output int lat, output logic [7:0] val,
                        output logic err, output int ens);
    int e0;
    @(negedge clk);
    req_valid = 1'b1;
    req_bound = n;
    e0 = en_count;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    val = rsp_value;
    err = rsp_error;
    ens = en_count - e0;
    $display("req N=%0d -> value=%0d error=%0b lat=%0d enables=%0d", n, val, err, lat, ens);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [7:0] val; logic err; int ens;
    bit stale;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (lfsr_enable !== 1'b0) begin errors++; $display("FAIL reset_lfsr_enable got=%b want=0", lfsr_enable); end
    checks++; if (rsp_value !== 8'd0) begin errors++; $display("FAIL reset_rsp_value got=%0d want=0", rsp_value); end
    checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error got=%b want=0", rsp_error); end
    rst = 1'b1;
    // All candidates rejected (c=12 with N=10), so the block stays in SAMPLE.
    load(8'h0C, 8'h0C, 8'h0C, 8'h0C);
    @(negedge clk);
    req_valid = 1'b1;
    req_bound = 8'd10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (lfsr_enable !== 1'b1) begin errors++; $display("FAIL mid_sample_enable got=%b want=1", lfsr_enable); end
    #2 rst = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL async_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (lfsr_enable !== 1'b0) begin errors++; $display("FAIL async_lfsr_enable got=%b want=0", lfsr_enable); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL async_req_ready got=%b want=1", req_ready); end
    @(negedge clk);
    rst = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || !req_ready) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL no_stale_rsp got=%b want=0", stale); end
    $display("reset mid-SAMPLE: aborted, idle afterwards");
    lat = 0; val = 0; err = 0; ens = 0;
  endtask

  task automatic test_direct();
    int lat; logic [7:0] val; logic err; int ens;
    load(8'h37, 8'h00, 8'h00, 8'h00);
    do_req(8'd10, lat, val, err, ens);
    checks++; if (val !== 8'd7) begin errors++; $display("FAIL direct_value got=%0d want=7", val); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL direct_error got=%b want=0", err); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL direct_latency got=%0d want=1", lat); end
    checks++; if (ens !== 1) begin errors++; $display("FAIL direct_enables got=%0d want=1", ens); end
    finish_rsp();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL direct_ready_after got=%b want=1", req_ready); end
  endtask

  task automatic test_retries();
    int lat; logic [7:0] val; logic err; int ens;
    load(8'h0C, 8'h0F, 8'h05, 8'h00);
    do_req(8'd10, lat, val, err, ens);
    checks++; if (val !== 8'd5) begin errors++; $display("FAIL retries_value got=%0d want=5", val); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL retries_latency got=%0d want=3", lat); end
    checks++; if (ens !== 3) begin errors++; $display("FAIL retries_enables got=%0d want=3", ens); end
    finish_rsp();
  endtask

  task automatic test_fallback();
    int lat; logic [7:0] val; logic err; int ens;
    load(8'h0C, 8'h0D, 8'h0E, 8'h0F);
    do_req(8'd10, lat, val, err, ens);
    checks++; if (val !== 8'd5) begin errors++; $display("FAIL fallback_value got=%0d want=5", val); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL fallback_latency got=%0d want=4", lat); end
    checks++; if (ens !== 4) begin errors++; $display("FAIL fallback_enables got=%0d want=4", ens); end
    finish_rsp();
  endtask

  task automatic test_edges();
    int lat; logic [7:0] val; logic err; int ens;
    load(8'h33, 8'h33, 8'h33, 8'h33);
    do_req(8'd0, lat, val, err, ens);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL zero_error got=%b want=1", err); end
    checks++; if (val !== 8'd0) begin errors++; $display("FAIL zero_value got=%0d want=0", val); end
    checks++; if (ens !== 0) begin errors++; $display("FAIL zero_enables got=%0d want=0", ens); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL zero_latency got=%0d want=0", lat); end
    finish_rsp();
    checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL zero_error_cleared got=%b want=0", rsp_error); end

    load(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    do_req(8'd1, lat, val, err, ens);
    checks++; if (val !== 8'd0) begin errors++; $display("FAIL one_value got=%0d want=0", val); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL one_latency got=%0d want=1", lat); end
    finish_rsp();

    load(8'hFF, 8'hFE, 8'h00, 8'h00);
    do_req(8'd255, lat, val, err, ens);
    checks++; if (val !== 8'hFE) begin errors++; $display("FAIL n255_value got=%0d want=254", val); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL n255_latency got=%0d want=2", lat); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int lat; logic [7:0] val; logic err; int ens;
    load(8'h03, 8'h00, 8'h00, 8'h00);
    do_req(8'd10, lat, val, err, ens);
    checks++; if (val !== 8'd3) begin errors++; $display("FAIL bp_value got=%0d want=3", val); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rsp_value !== 8'd3) begin errors++; $display("FAIL bp_hold_value cyc=%0d got=%0d want=3", i, rsp_value); end
      checks++; if (lfsr_enable !== 1'b0) begin errors++; $display("FAIL bp_hold_enable cyc=%0d got=%b want=0", i, lfsr_enable); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready cyc=%0d got=%b want=0", i, req_ready); end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", i, rsp_valid); end
    end
    load(8'h02, 8'h00, 8'h00, 8'h00);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_bound = 8'd10;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got=%b want=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_valid got=%b want=0", rsp_valid); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (lfsr_enable !== 1'b1) begin errors++; $display("FAIL bp_new_sample got=%b want=1", lfsr_enable); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_new_valid got=%b want=1", rsp_valid); end
    checks++; if (rsp_value !== 8'd2) begin errors++; $display("FAIL bp_new_value got=%0d want=2", rsp_value); end
    $display("backpressure: held 5 cycles, follow-on value=%0d", rsp_value);
    finish_rsp();
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_bound = 8'd0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) tab[i] = '0;
    test_reset();
    test_direct();
    test_retries();
    test_fallback();
    test_edges();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_range.md
# rand_range

Converts the raw pseudo-random word from the upstream `lfsr` into an unbiased integer in `[0, bound)` for consumers such as random cache-way replacement and test-pattern injection. It sits directly downstream of `lfsr`, consumes its `data` output, and owns that instance's `enable` input, so the LFSR advances only when a value is consumed. Requests and responses use valid/ready handshakes. Sampling is by masked rejection, with a bounded retry count so worst-case latency is fixed.

## Interface
- `LfsrWidth`, default 31: width of the LFSR word; must be >= `OutWidth`.
- `OutWidth`, default 8: width of `bound` and of the result.
- `MaxRetries`, default 3: rejected candidates allowed before the forced fallback; must be >= 1.

- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `lfsr_data`  in  `LfsrWidth`  current LFSR register value (`lfsr.data`).
- `lfsr_enable`  out  1  advance request to the LFSR (`lfsr.enable`).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_bound`  in  `OutWidth`  exclusive upper bound N.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_value`  out  `OutWidth`  result in `[0, N)`.
- `rsp_error`  out  1  set with the response when N == 0.

## Operation
- Reset forces all registered state immediately, without waiting for a clock edge:
  - state = IDLE, `tries_q` = 0, `bound_q` = 0, `mask_q` = 0;
  - `rsp_value` = 0, `rsp_error` = 0, `rsp_valid` = 0, `lfsr_enable` = 0, `req_ready` = 1.
- FSM states: IDLE, SAMPLE, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch `bound_q` = N and `tries_q` = 0.
  - `mask_q` = (N-1) with every bit below its MSB set; N == 1 gives mask 0.
  - If N == 0, go to RESP with `rsp_error` = 1 and `rsp_value` = 0. The LFSR is not advanced.
  - Otherwise go to SAMPLE.
- **SAMPLE**
  - `lfsr_enable` = 1 every cycle in this state, so each cycle consumes exactly one LFSR word.
  - Candidate c = `lfsr_data[OutWidth-1:0]` & `mask_q`.
  - If c < `bound_q`: `rsp_value` = c, go to RESP.
  - Else, if `tries_q` == `MaxRetries`: `rsp_value` = c - `bound_q`, go to RESP. This is always in range because c < 2*N.
  - Otherwise `tries_q` += 1 and stay in SAMPLE.
  - Comparison and subtraction are unsigned, `OutWidth` bits wide.
- **RESP**
  - `rsp_valid` = 1; `rsp_value` and `rsp_error` are held stable.
  - On `rsp_ready`: go to IDLE and clear `rsp_error`.
  - `req_ready` = 0, and `lfsr_enable` = 0.
- `lfsr_enable` is 0 in IDLE and RESP, so the LFSR is frozen while no value is being consumed.

## Timing
- Request accepted at edge E0. SAMPLE occupies cycle 1.
- With no rejection, `rsp_valid` is high from after edge E1.
- Each rejection adds one cycle. Worst case: `rsp_valid` after edge E(1+`MaxRetries`).
- N == 0: `rsp_valid` is high after E0.
- The LFSR word advances at the edge ending each SAMPLE cycle, so the next SAMPLE cycle sees a fresh word.
- Response and request never overlap. After the `rsp_ready` edge the block is in IDLE, with `req_ready` = 1 the following cycle. Minimum period is 3 cycles per result.
- `req_ready`, `rsp_valid` and `lfsr_enable` decode from the state register only. None has a combinational path from `req_valid` or `rsp_ready`.
- Reset mid-SAMPLE or mid-RESP aborts the transaction. Outputs are at reset values asynchronously; no response is issued for the aborted request.

## Test plan
- **Reset:** assert `rst` = 0 mid-SAMPLE with N = 10.
  - Outputs drop immediately: `rsp_valid` = 0, `lfsr_enable` = 0, `req_ready` = 1.
  - After release, no stale response appears.
- **Direct accept:** N = 10 (mask 0xF), `lfsr_data` low byte 0x37 (c = 7).
  - `rsp_value` = 7, `rsp_error` = 0.
  - `rsp_valid` high 2 cycles after request; exactly one `lfsr_enable` pulse.
- **Retries:** N = 10, successive low bytes 0x0C, 0x0F, 0x05 (c = 12, 15, 5).
  - `rsp_value` = 5 after 3 SAMPLE cycles; three `lfsr_enable` pulses.
- **Fallback:** `MaxRetries` = 3, N = 10, four successive candidates 12, 13, 14, 15.
  - `rsp_value` = 15 - 10 = 5 on the 4th candidate; latency 5 cycles.
- **Edges:**
  - N = 0 gives `rsp_error` = 1, `rsp_value` = 0, no `lfsr_enable`.
  - N = 1 gives `rsp_value` = 0 for any LFSR word.
  - N = 255 with low byte 0xFF is rejected; 0xFE is accepted.
- **Backpressure:** hold `rsp_ready` = 0 for 5 cycles in RESP.
  - `rsp_value` stays stable, `lfsr_enable` = 0, `req_ready` = 0.
  - Release `rsp_ready` with `req_valid` high: the new request is accepted on the cycle after the handshake.
